// File: rtl/sync_fifo_if.sv
// Write/read request bundle for sync_fifo; the master side is the producer/consumer, the slave side is the FIFO.
// Handshake: a write completes on a rising edge where wen=1 and wfull=0; a read completes where ren=1 and rempty=0.
interface sync_fifo_if #(
  parameter int WIDTH = 8
);
  logic             wen;
  logic [WIDTH-1:0] din;
  logic             ren;
  logic [WIDTH-1:0] dout;
  logic             wfull;
  logic             rempty;

  modport master (
    output wen, din, ren,
    input  dout, wfull, rempty
  );

  modport slave (
    input  wen, din, ren,
    output dout, wfull, rempty
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary (non power-of-two) depth, registered read data
// and flags derived only from the registered occupancy count.
module sync_fifo #(
  parameter int DEPTH = 22,
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  sync_fifo_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full, empty, do_wr, do_rd;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign do_wr  = bus.wen && !full;
  assign do_rd  = bus.ren && !empty;

  assign bus.wfull  = full;
  assign bus.rempty = empty;
  assign bus.dout   = dout_q;

  // Explicit compare-and-clear wrap, since DEPTH need not be a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (do_wr) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (do_rd) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      dout_d = mem[rptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is left uncleared by reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_wr && !rst_n) begin
      mem[wptr_q] <= bus.din;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_sync_fifo;
  localparam int DEPTH = 22;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  sync_fifo_if #(.WIDTH(WIDTH)) bus();

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_dout;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      exp_q.delete();
      m_dout = '0;
    end else begin
      bit can_w;
      bit can_r;
      can_w = bus.wen && (exp_q.size() < DEPTH);
      can_r = bus.ren && (exp_q.size() > 0);
      if (can_r) m_dout = exp_q.pop_front();
      if (can_w) exp_q.push_back(bus.din);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_dout",   32'(bus.dout),   32'(m_dout));
    check("cyc_wfull",  32'(bus.wfull),  32'(exp_q.size() == DEPTH));
    check("cyc_rempty", 32'(bus.rempty), 32'(exp_q.size() == 0));
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bus.wen = w;
    bus.ren = r;
    bus.din = d;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
  endtask

  task automatic write(input logic [WIDTH-1:0] d);
    cycle(1'b1, 1'b0, d);
  endtask

  task automatic read();
    cycle(1'b0, 1'b1, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    bus.din = '0;
    rst_n   = 1'b1;

    // Requests during reset have no effect.
    cycle(1'b1, 1'b0, 8'h33);
    cycle(1'b1, 1'b1, 8'h34);
    check("rst_dout",   32'(bus.dout),   32'h0);
    check("rst_rempty", 32'(bus.rempty), 32'h1);
    check("rst_wfull",  32'(bus.wfull),  32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Fill: A0..B5.
    for (int i = 0; i < DEPTH; i++) begin
      write(8'(8'hA0 + i));
      check("fill_rempty", 32'(bus.rempty), 32'h0);
      check("fill_wfull",  32'(bus.wfull),  32'(i == DEPTH - 1));
    end
    check("fill_model_size", 32'(exp_q.size()), 32'd22);

    // Overflow attempts are dropped.
    write(8'hEE);
    write(8'hEF);
    check("ovf_wfull",      32'(bus.wfull),    32'h1);
    check("ovf_model_size", 32'(exp_q.size()), 32'd22);

    // Drain, each value one clock after its read edge.
    for (int i = 0; i < DEPTH; i++) begin
      read();
      check("drain_dout",   32'(bus.dout),   32'(8'(8'hA0 + i)));
      check("drain_rempty", 32'(bus.rempty), 32'(i == DEPTH - 1));
    end
    read();
    check("extra_read_dout", 32'(bus.dout),   32'h000000B5);
    check("extra_rempty",    32'(bus.rempty), 32'h1);

    // Wrap: 15 in/out, then a full lap of 22.
    for (int i = 0; i < 15; i++) write(8'(8'h40 + i));
    for (int i = 0; i < 15; i++) read();
    check("wrap1_dout", 32'(bus.dout), 32'h0000004E);
    for (int i = 0; i < DEPTH; i++) write(8'(8'h60 + i));
    check("wrap_full", 32'(bus.wfull), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      read();
      check("wrap2_dout", 32'(bus.dout), 32'(8'(8'h60 + i)));
    end

    // Simultaneous read/write at count=10.
    for (int i = 0; i < 10; i++) write(8'(8'h80 + i));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h90 + i));
      check("sim_dout",   32'(bus.dout),   32'(8'(8'h80 + i)));
      check("sim_wfull",  32'(bus.wfull),  32'h0);
      check("sim_rempty", 32'(bus.rempty), 32'h0);
    end
    check("sim_model_size", 32'(exp_q.size()), 32'd10);

    // Simultaneous at full: only the read goes through.
    for (int i = 0; i < 12; i++) write(8'(8'hC0 + i));
    check("full_before_sim", 32'(bus.wfull), 32'h1);
    cycle(1'b1, 1'b1, 8'hFF);
    check("simfull_dout",  32'(bus.dout),  32'h00000085);
    check("simfull_wfull", 32'(bus.wfull), 32'h0);
    check("simfull_size",  32'(exp_q.size()), 32'd21);
    for (int i = 0; i < 21; i++) read();
    check("simfull_last", 32'(bus.dout), 32'h000000CB);
    check("drained_empty", 32'(bus.rempty), 32'h1);

    // Simultaneous at empty: write only, no fall-through.
    cycle(1'b1, 1'b1, 8'h77);
    check("simempty_dout",   32'(bus.dout),   32'h000000CB);
    check("simempty_rempty", 32'(bus.rempty), 32'h0);
    read();
    check("simempty_read", 32'(bus.dout), 32'h00000077);

    // Reset mid-operation at count=7.
    for (int i = 0; i < 8; i++) write(8'(8'h10 + i));
    read();
    check("pre_rst_dout", 32'(bus.dout), 32'h00000010);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_dout",   32'(bus.dout),   32'h0);
    check("midrst_rempty", 32'(bus.rempty), 32'h1);
    check("midrst_wfull",  32'(bus.wfull),  32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    write(8'h5A);
    read();
    check("post_rst_dout", 32'(bus.dout), 32'h0000005A);
    check("post_rst_empty", 32'(bus.rempty), 32'h1);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 22, number of storage entries; any integer >= 2, power of two not required.
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge except reset.
REQ-004 rst_n  input  1  reset, asynchronous and active-high: asserted when 1 despite the _n suffix.
REQ-005 wen  input  1  write request.
REQ-006 din  input  WIDTH  write data, sampled on the rising edge when a write is accepted.
REQ-007 ren  input  1  read request.
REQ-008 dout  output  WIDTH  registered read data.
REQ-009 wfull  output  1  FIFO holds DEPTH entries.
REQ-010 rempty  output  1  FIFO holds 0 entries.

Function
REQ-011 The block SHALL keep a write pointer and a read pointer, each ranging 0..DEPTH-1, plus an occupancy count ranging 0..DEPTH.
REQ-012 Each pointer SHALL wrap from DEPTH-1 to 0; no power-of-two arithmetic is permitted.
REQ-013 A write SHALL be accepted on a rising edge when wen=1 and wfull=0: din is stored at the write pointer and the write pointer advances by 1.
REQ-014 A read SHALL be accepted on a rising edge when ren=1 and rempty=0: the entry at the read pointer loads into dout on that edge and the read pointer advances by 1; read latency is one clock.
REQ-015 Acceptance SHALL use the flag values present before the edge.
REQ-016 A write while full SHALL be ignored: no storage, pointer or count change.
REQ-017 A read while empty SHALL be ignored: dout holds its value and no pointer or count changes.
REQ-018 Occupancy count SHALL change as follows: +1 on write only, -1 on read only, unchanged when both are accepted or neither is.
REQ-019 When both are requested with 0<count<DEPTH, both SHALL be accepted in the same cycle.
REQ-020 When both are requested while empty, only the write SHALL be accepted, with no fall-through; dout updates no earlier than the following read.
REQ-021 When both are requested while full, only the read SHALL be accepted.
REQ-022 wfull SHALL equal (count==DEPTH) and rempty SHALL equal (count==0), both derived from registered state with no combinational path from wen/ren/din.
REQ-023 dout SHALL hold its last value whenever no read is accepted.
REQ-024 Data SHALL exit in exact write order (first-in, first-out) across any number of pointer wraps.

Reset
REQ-025 While rst_n=1, regardless of clk: pointers=0, count=0, dout=0, rempty=1, wfull=0.
REQ-026 Storage contents need not be cleared by reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries immediately.
REQ-028 The first accepted write after rst_n deasserts SHALL land at entry 0.
REQ-029 wen/ren SHALL have no effect while rst_n=1.

Verification
REQ-030 Fill: after reset, 22 consecutive writes of distinct values -> wfull=1 after the 22nd edge, rempty=0 after the 1st, wfull=0 through writes 1-21.
REQ-031 Overflow: 2 further writes while full -> ignored; count stays 22; later drain returns only the first 22 values.
REQ-032 Drain: 22 consecutive reads -> dout presents the written values in order, each one clock after its read edge; rempty=1 after the 22nd read; an extra read leaves dout at the 22nd value.
REQ-033 Wrap: write 15, read 15, then write 22 and read 22 -> pointers wrap past 21 and all data is returned in order without loss.
REQ-034 Simultaneous: at count=10, assert wen and ren together for 5 cycles -> count stays 10, flags unchanged, output order preserved; repeat at full (read only) and at empty (write only).
REQ-035 Reset mid-operation: at count=7, pulse rst_n high between clock edges -> immediate rempty=1, wfull=0, dout=0; a subsequent write then read returns the new value.
